// File: rtl/mem_port_arbiter.sv
// Shares one SRAM-like memory port between the fetch and data requesters.
// Tracks up to two in-order outstanding transactions and routes each response back to its issuer.
module mem_port_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int MAX_DATA_RUN = 4
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                inst_req,
  input  logic [ADDR_W-1:0]   inst_addr,
  output logic                inst_addr_ok,
  output logic                inst_data_ok,
  output logic [DATA_W-1:0]   inst_rdata,
  input  logic                data_req,
  input  logic                data_wr,
  input  logic [DATA_W/8-1:0] data_wstrb,
  input  logic [ADDR_W-1:0]   data_addr,
  input  logic [DATA_W-1:0]   data_wdata,
  output logic                data_addr_ok,
  output logic                data_data_ok,
  output logic [DATA_W-1:0]   data_rdata,
  output logic                mem_req,
  output logic                mem_wr,
  output logic [DATA_W/8-1:0] mem_wstrb,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic                mem_addr_ok,
  input  logic                mem_data_ok,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic                err_unexp
);

  localparam int STRB_W = DATA_W / 8;
  localparam int RUN_W  = $clog2(MAX_DATA_RUN + 1);
  localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(MAX_DATA_RUN);
  localparam logic SRC_INST = 1'b0;
  localparam logic SRC_DATA = 1'b1;

  logic [1:0]       r_out_cnt;
  logic [1:0]       r_tag;
  logic             r_wptr;
  logic             r_rptr;
  logic             r_lock_vld;
  logic             r_lock_src;
  logic [RUN_W-1:0] r_run_cnt;
  logic             r_err_unexp;

  logic w_grant;
  logic w_greq;
  logic w_full;
  logic w_mem_req;
  logic w_accept;
  logic w_pop_vld;
  logic w_head;

  assign w_full = (r_out_cnt == 2'd2);

  // Grant source: a stalled address phase keeps its grant; otherwise a waiting fetch wins after a full data run.
  always_comb begin
    w_grant = SRC_INST;
    if (r_lock_vld) begin
      w_grant = r_lock_src;
    end else if ((r_run_cnt == RUN_MAX) && inst_req) begin
      w_grant = SRC_INST;
    end else if (data_req) begin
      w_grant = SRC_DATA;
    end else begin
      w_grant = SRC_INST;
    end
  end

  assign w_greq    = (w_grant == SRC_DATA) ? data_req : inst_req;
  assign w_mem_req = w_greq & ~w_full & resetn;
  assign w_accept  = w_mem_req & mem_addr_ok;
  assign w_pop_vld = mem_data_ok & (r_out_cnt != 2'd0) & resetn;
  assign w_head    = r_tag[r_rptr];

  assign mem_req   = w_mem_req;
  assign mem_wr    = (w_grant == SRC_DATA) & data_wr;
  assign mem_wstrb = (w_grant == SRC_DATA) ? data_wstrb : {STRB_W{1'b0}};
  assign mem_addr  = (w_grant == SRC_DATA) ? data_addr  : inst_addr;
  assign mem_wdata = (w_grant == SRC_DATA) ? data_wdata : {DATA_W{1'b0}};

  assign inst_addr_ok = w_accept & (w_grant == SRC_INST);
  assign data_addr_ok = w_accept & (w_grant == SRC_DATA);
  assign inst_data_ok = w_pop_vld & (w_head == SRC_INST);
  assign data_data_ok = w_pop_vld & (w_head == SRC_DATA);
  assign inst_rdata   = mem_rdata;
  assign data_rdata   = mem_rdata;
  assign err_unexp    = r_err_unexp;

  // Outstanding count, response tag FIFO, grant lock, data run length and sticky error.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_out_cnt   <= 2'd0;
      r_tag       <= 2'b00;
      r_wptr      <= 1'b0;
      r_rptr      <= 1'b0;
      r_lock_vld  <= 1'b0;
      r_lock_src  <= SRC_INST;
      r_run_cnt   <= {RUN_W{1'b0}};
      r_err_unexp <= 1'b0;
    end else begin
      case ({w_accept, w_pop_vld})
        2'b10:   r_out_cnt <= r_out_cnt + 2'd1;
        2'b01:   r_out_cnt <= r_out_cnt - 2'd1;
        default: r_out_cnt <= r_out_cnt;
      endcase

      if (w_accept) begin
        r_tag[r_wptr] <= w_grant;
        r_wptr        <= ~r_wptr;
      end
      if (w_pop_vld) begin
        r_rptr <= ~r_rptr;
      end

      if (w_accept) begin
        r_lock_vld <= 1'b0;
      end else if (w_mem_req) begin
        r_lock_vld <= 1'b1;
        r_lock_src <= w_grant;
      end

      if (!inst_req || (w_accept && (w_grant == SRC_INST))) begin
        r_run_cnt <= {RUN_W{1'b0}};
      end else if (w_accept && (r_run_cnt != RUN_MAX)) begin
        r_run_cnt <= r_run_cnt + RUN_W'(1);
      end

      if (mem_data_ok && (r_out_cnt == 2'd0)) begin
        r_err_unexp <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed cycle table, hand-written corner
// sequences, then random traffic against a queue-based reference model.
module tb_mem_port_arbiter;

  localparam int AW   = 32;
  localparam int DW   = 32;
  localparam int SW   = DW / 8;
  localparam int MAXR = 4;

  logic          clk = 1'b0;
  logic          resetn;
  logic          inst_req, inst_addr_ok, inst_data_ok;
  logic [AW-1:0] inst_addr;
  logic [DW-1:0] inst_rdata;
  logic          data_req, data_wr, data_addr_ok, data_data_ok;
  logic [SW-1:0] data_wstrb;
  logic [AW-1:0] data_addr;
  logic [DW-1:0] data_wdata, data_rdata;
  logic          mem_req, mem_wr, mem_addr_ok, mem_data_ok, err_unexp;
  logic [SW-1:0] mem_wstrb;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;

  int n_chk = 0;
  int n_err = 0;

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_DATA_RUN(MAXR)) dut (
    .clk(clk), .resetn(resetn),
    .inst_req(inst_req), .inst_addr(inst_addr), .inst_addr_ok(inst_addr_ok),
    .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
    .data_req(data_req), .data_wr(data_wr), .data_wstrb(data_wstrb), .data_addr(data_addr),
    .data_wdata(data_wdata), .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok),
    .data_rdata(data_rdata),
    .mem_req(mem_req), .mem_wr(mem_wr), .mem_wstrb(mem_wstrb), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_addr_ok(mem_addr_ok), .mem_data_ok(mem_data_ok),
    .mem_rdata(mem_rdata), .err_unexp(err_unexp)
  );

  always #5 clk = ~clk;

  task automatic chk1(input string nm, input logic act, input logic exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %b expected %b", nm, $time, act, exp);
    end
  endtask

  task automatic chkw(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got 0x%08h expected 0x%08h", nm, $time, act, exp);
    end
  endtask

  task automatic idle_inputs();
    inst_req = 1'b0; inst_addr = 32'h0;
    data_req = 1'b0; data_wr = 1'b0; data_wstrb = 4'h0; data_addr = 32'h0; data_wdata = 32'h0;
    mem_addr_ok = 1'b0; mem_data_ok = 1'b0; mem_rdata = 32'h0;
  endtask

  // Leaves time at posedge+1 with reset released.
  task automatic do_reset();
    idle_inputs();
    resetn = 1'b0;
    repeat (2) @(posedge clk);
    #1 resetn = 1'b1;
  endtask

  typedef struct {
    logic ireq, dreq, dwr, maok, mdok;
    logic [31:0] rdata;
    logic e_mreq, e_gdata, e_iaok, e_daok, e_idok, e_ddok, e_err;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic ireq, dreq, dwr, maok, mdok, input logic [31:0] rdata,
                              input logic e_mreq, e_gdata, e_iaok, e_daok, e_idok, e_ddok, e_err);
    vec_t v;
    v.ireq = ireq; v.dreq = dreq; v.dwr = dwr; v.maok = maok; v.mdok = mdok; v.rdata = rdata;
    v.e_mreq = e_mreq; v.e_gdata = e_gdata; v.e_iaok = e_iaok; v.e_daok = e_daok;
    v.e_idok = e_idok; v.e_ddok = e_ddok; v.e_err = e_err;
    return v;
  endfunction

  initial begin
    string exp_pat;
    string got_pat;
    logic  prev_i, prev_d;
    // reference model state
    bit    mq[$];
    bit    pend, psrc, ip, dp, dw;
    int    run;
    logic [31:0] ia, da, dwd;
    logic [3:0]  dws;
    bit    g, greq, mreq_m, acc, pop, head;

    //          ireq dreq dwr maok mdok rdata         mreq gD  iaok daok idok ddok err
    tbl.push_back(mk(1, 0, 0, 1, 0, 32'h0,          1, 0, 1, 0, 0, 0, 0)); // single fetch
    tbl.push_back(mk(0, 0, 0, 0, 0, 32'h0,          0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 1, 32'h02800C0C,   0, 0, 0, 0, 1, 0, 0));
    tbl.push_back(mk(0, 1, 1, 0, 0, 32'h0,          1, 1, 0, 0, 0, 0, 0)); // store stalls, locks
    tbl.push_back(mk(1, 1, 1, 0, 0, 32'h0,          1, 1, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 1, 1, 0, 0, 32'h0,          1, 1, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 1, 1, 1, 0, 32'h0,          1, 1, 0, 1, 0, 0, 0));
    tbl.push_back(mk(1, 0, 0, 1, 0, 32'h0,          1, 0, 1, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 0, 1, 0, 32'h0,          0, 1, 0, 0, 0, 0, 0)); // full
    tbl.push_back(mk(0, 1, 0, 1, 1, 32'h11112222,   0, 1, 0, 0, 0, 1, 0)); // pop, no bypass
    tbl.push_back(mk(0, 1, 0, 1, 1, 32'h33334444,   1, 1, 0, 1, 1, 0, 0)); // accept+pop
    tbl.push_back(mk(0, 0, 0, 0, 1, 32'h55556666,   0, 0, 0, 0, 0, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0, 1, 32'h0,          0, 0, 0, 0, 0, 0, 0)); // unexpected
    tbl.push_back(mk(0, 0, 0, 0, 0, 32'h0,          0, 0, 0, 0, 0, 0, 1));
    tbl.push_back(mk(1, 0, 0, 1, 0, 32'h0,          1, 0, 1, 0, 0, 0, 1));
    tbl.push_back(mk(0, 0, 0, 0, 1, 32'h0BADF00D,   0, 0, 0, 0, 1, 0, 1));

    do_reset();
    #2;
    chk1("reset_mem_req", mem_req, 1'b0);
    chk1("reset_err", err_unexp, 1'b0);
    @(posedge clk); #1;

    foreach (tbl[k]) begin
      inst_req = tbl[k].ireq; inst_addr = 32'h1C000000;
      data_req = tbl[k].dreq; data_wr = tbl[k].dwr; data_wstrb = 4'hF;
      data_addr = 32'h80000010; data_wdata = 32'hCAFE0001;
      mem_addr_ok = tbl[k].maok; mem_data_ok = tbl[k].mdok; mem_rdata = tbl[k].rdata;
      #2;
      chk1($sformatf("tbl%0d_mem_req", k), mem_req, tbl[k].e_mreq);
      if (tbl[k].e_mreq) begin
        chkw($sformatf("tbl%0d_mem_addr", k), mem_addr, tbl[k].e_gdata ? 32'h80000010 : 32'h1C000000);
        chk1($sformatf("tbl%0d_mem_wr", k), mem_wr, tbl[k].e_gdata & tbl[k].dwr);
        chkw($sformatf("tbl%0d_mem_wstrb", k), {28'd0, mem_wstrb}, tbl[k].e_gdata ? 32'hF : 32'h0);
      end
      chk1($sformatf("tbl%0d_inst_addr_ok", k), inst_addr_ok, tbl[k].e_iaok);
      chk1($sformatf("tbl%0d_data_addr_ok", k), data_addr_ok, tbl[k].e_daok);
      chk1($sformatf("tbl%0d_inst_data_ok", k), inst_data_ok, tbl[k].e_idok);
      chk1($sformatf("tbl%0d_data_data_ok", k), data_data_ok, tbl[k].e_ddok);
      chk1($sformatf("tbl%0d_err_unexp", k), err_unexp, tbl[k].e_err);
      if (tbl[k].e_idok) chkw($sformatf("tbl%0d_inst_rdata", k), inst_rdata, tbl[k].rdata);
      if (tbl[k].e_ddok) chkw($sformatf("tbl%0d_data_rdata", k), data_rdata, tbl[k].rdata);
      @(posedge clk); #1;
    end

    // Starvation guard: both requesters held, memory accepts every cycle, 1-cycle response.
    do_reset();
    exp_pat = "DDDDIDDDDIDD";
    got_pat = "";
    prev_i = 1'b0; prev_d = 1'b0;
    for (int c = 0; c < 12; c++) begin
      inst_req = 1'b1; inst_addr = 32'h1C000100 + 32'(c * 4);
      data_req = 1'b1; data_addr = 32'h80000200 + 32'(c * 4);
      mem_addr_ok = 1'b1; mem_data_ok = prev_i | prev_d; mem_rdata = 32'(c);
      #2;
      got_pat = {got_pat, inst_addr_ok ? "I" : (data_addr_ok ? "D" : "-")};
      chk1($sformatf("starve%0d_iaok", c), inst_addr_ok, exp_pat[c] == "I");
      chk1($sformatf("starve%0d_daok", c), data_addr_ok, exp_pat[c] == "D");
      chk1($sformatf("starve%0d_idok", c), inst_data_ok, prev_i);
      chk1($sformatf("starve%0d_ddok", c), data_data_ok, prev_d);
      prev_i = inst_addr_ok; prev_d = data_addr_ok;
      @(posedge clk); #1;
    end
    if (got_pat != exp_pat) $display("starvation order seen: %s", got_pat);

    // Reset mid-operation with two transactions outstanding.
    do_reset();
    inst_req = 1'b1; inst_addr = 32'h1C000000; mem_addr_ok = 1'b1;
    #2 chk1("rst_mid_iaok", inst_addr_ok, 1'b1);
    @(posedge clk); #1;
    inst_req = 1'b0; data_req = 1'b1; data_addr = 32'h80000040; mem_addr_ok = 1'b1;
    #2 chk1("rst_mid_daok", data_addr_ok, 1'b1);
    @(posedge clk); #1;
    inst_req = 1'b1; data_req = 1'b0;
    #2 chk1("rst_mid_full_mem_req", mem_req, 1'b0);
    resetn = 1'b0; mem_data_ok = 1'b1;
    #1;
    chk1("rst_mid_mem_req", mem_req, 1'b0);
    chk1("rst_mid_iaok_low", inst_addr_ok, 1'b0);
    chk1("rst_mid_idok_low", inst_data_ok, 1'b0);
    chk1("rst_mid_ddok_low", data_data_ok, 1'b0);
    repeat (2) @(posedge clk);
    #1 resetn = 1'b1; mem_data_ok = 1'b0; inst_req = 1'b1; mem_addr_ok = 1'b1;
    #2;
    chk1("rst_after_mem_req", mem_req, 1'b1);
    chk1("rst_after_iaok", inst_addr_ok, 1'b1);
    @(posedge clk); #1;
    inst_req = 1'b0; mem_addr_ok = 1'b0; mem_data_ok = 1'b1; mem_rdata = 32'h02800C0C;
    #2;
    chk1("rst_after_idok", inst_data_ok, 1'b1);
    chk1("rst_after_ddok", data_data_ok, 1'b0);
    chkw("rst_after_rdata", inst_rdata, 32'h02800C0C);
    chk1("rst_after_err", err_unexp, 1'b0);
    @(posedge clk); #1;

    // Random traffic against a reference model.
    do_reset();
    mq.delete(); pend = 0; psrc = 0; run = 0; ip = 0; dp = 0;
    ia = 32'h0; da = 32'h0; dwd = 32'h0; dws = 4'h0; dw = 0;
    for (int c = 0; c < 2000; c++) begin
      if (!ip && $urandom_range(0, 2) != 0) begin ip = 1; ia = $urandom & 32'hFFFFFFFC; end
      if (!dp && $urandom_range(0, 3) != 0) begin
        dp = 1; da = $urandom; dw = 1'($urandom_range(0, 1));
        dws = dw ? 4'($urandom_range(1, 15)) : 4'h0; dwd = $urandom;
      end
      inst_req = ip; inst_addr = ia;
      data_req = dp; data_addr = da; data_wr = dw; data_wstrb = dws; data_wdata = dwd;
      mem_addr_ok = ($urandom_range(0, 3) != 0);
      mem_data_ok = (mq.size() > 0) && ($urandom_range(0, 1) == 1);
      mem_rdata = $urandom;
      #2;
      if (pend) g = psrc;
      else if (run == MAXR && ip) g = 0;
      else if (dp) g = 1;
      else g = 0;
      greq   = g ? dp : ip;
      mreq_m = greq && (mq.size() < 2);
      acc    = mreq_m && mem_addr_ok;
      pop    = mem_data_ok && (mq.size() > 0);
      head   = (mq.size() > 0) ? mq[0] : 1'b0;
      chk1("rnd_mem_req", mem_req, mreq_m);
      if (mreq_m) begin
        chkw("rnd_mem_addr", mem_addr, g ? da : ia);
        chk1("rnd_mem_wr", mem_wr, g & dw);
        chkw("rnd_mem_wstrb", {28'd0, mem_wstrb}, g ? {28'd0, dws} : 32'h0);
        if (g) chkw("rnd_mem_wdata", mem_wdata, dwd);
      end
      chk1("rnd_inst_addr_ok", inst_addr_ok, acc && !g);
      chk1("rnd_data_addr_ok", data_addr_ok, acc && g);
      chk1("rnd_inst_data_ok", inst_data_ok, pop && !head);
      chk1("rnd_data_data_ok", data_data_ok, pop && head);
      if (pop) chkw("rnd_rdata", head ? data_rdata : inst_rdata, mem_rdata);
      chk1("rnd_err", err_unexp, 1'b0);
      if (pop) void'(mq.pop_front());
      if (acc) mq.push_back(g);
      if (acc) pend = 0;
      else if (mreq_m) begin pend = 1; psrc = g; end
      if (!ip || (acc && !g)) run = 0;
      else if (acc && g && run < MAXR) run++;
      if (acc && !g) ip = 0;
      if (acc && g) dp = 0;
      @(posedge clk); #1;
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares one SRAM-like memory port between the CPU's instruction-fetch requester and data requester. It sits between the pipeline top's `inst_sram_*`/`data_sram_*` side and the single memory or bridge port. It uses SRAM-like `req/addr_ok/data_ok` handshakes on every side. It arbitrates address phases, tracks up to two outstanding transactions in order and routes each response back to the requester that issued it.

## Interface
- `ADDR_W`, 32, address width
- `DATA_W`, 32, data width; `wstrb` is `DATA_W/8` bits
- `MAX_DATA_RUN`, 4, consecutive data grants allowed while `inst_req` waits

Ports:
- `clk` in 1: single clock; all state on rising edge
- `resetn` in 1: asynchronous, active-low reset
- `inst_req` in 1: fetch request; held until `inst_addr_ok`
- `inst_addr` in ADDR_W: fetch address
- `inst_addr_ok` out 1: fetch address accepted
- `inst_data_ok` out 1: fetch data returned
- `inst_rdata` out DATA_W: fetch data
- `data_req` in 1: load/store request; held until `data_addr_ok`
- `data_wr` in 1: 1 = store
- `data_wstrb` in DATA_W/8: byte strobes
- `data_addr` in ADDR_W: data address
- `data_wdata` in DATA_W: store data
- `data_addr_ok` out 1: data address accepted
- `data_data_ok` out 1: load data or store completion
- `data_rdata` out DATA_W: load data
- `mem_req`, `mem_wr`, `mem_wstrb`, `mem_addr`, `mem_wdata` out: shared port request; a fetch drives `mem_wr`=0 and `mem_wstrb`=0
- `mem_addr_ok` in 1: memory accepted the address
- `mem_data_ok` in 1: memory response; always in issue order
- `mem_rdata` in DATA_W: response data
- `err_unexp` out 1: sticky; `mem_data_ok` arrived with no transaction outstanding

## Operation
State:
- `out_cnt` (0..2)
- 2-entry tag FIFO: 1 bit per entry, 0 = inst, 1 = data
- `lock_vld` and `lock_src`
- `run_cnt` (0..MAX_DATA_RUN)
- `err_unexp`

Grant selection, combinational:
- If `lock_vld`=1: grant = `lock_src`.
- Else if `run_cnt`==MAX_DATA_RUN and `inst_req`=1: grant = inst.
- Else if `data_req`=1: grant = data.
- Else if `inst_req`=1: grant = inst.

Request output:
- `mem_req` = granted source's req AND `out_cnt`<2.
- `mem_*` fields mux from the granted source.

Address handshake:
- Accept = `mem_req` & `mem_addr_ok`.
- The granted source's `*_addr_ok` = accept. The other source's `*_addr_ok` = 0.
- On accept: push the grant tag into the FIFO and clear `lock_vld`.
- If `mem_req`=1 and `mem_addr_ok`=0: set `lock_vld`, `lock_src` = grant. The grant must not switch while a request is pending on the port.

Response:
- When `mem_data_ok`=1 and `out_cnt`>0: pop the FIFO head. Assert `inst_data_ok` or `data_data_ok` according to the head tag.
- `inst_rdata` = `data_rdata` = `mem_rdata` (unqualified).
- When `mem_data_ok`=1 and `out_cnt`==0: set `err_unexp`. No `*_data_ok` is asserted and the FIFO is unchanged.

Counters:
- `out_cnt`: +1 on accept, −1 on valid pop, unchanged when both happen in one cycle.
- `run_cnt`:
  - Cleared when `inst_req`=0 or on an inst accept.
  - Incremented, saturating at MAX_DATA_RUN, on a data accept while `inst_req`=1.

## Timing
- Zero-cycle combinational paths:
  - `*_req` → `mem_req`
  - `mem_addr_ok` → `*_addr_ok`
  - `mem_data_ok`/`mem_rdata` → `*_data_ok`/`*_rdata`
- No register sits in any forward path.
- Reset (`resetn`=0, asynchronous):
  - `out_cnt`=0, FIFO empty, `lock_vld`=0, `run_cnt`=0, `err_unexp`=0.
  - `mem_req`, `inst_addr_ok`, `data_addr_ok`, `inst_data_ok`, `data_data_ok` forced to 0 while reset is asserted.
  - In-flight transactions are discarded; the memory side is reset together with this block.
- Full (`out_cnt`==2): `mem_req`=0. A pop in the same cycle does not bypass, so accepts resume the next cycle.
- Empty: a pop is ignored and only sets `err_unexp`.
- Accept and pop in the same cycle: both take effect. FIFO pointers wrap modulo 2.
- Maximum throughput: one accept per cycle. Back-to-back responses: one per cycle.

## Test plan
- Single fetch: `inst_req`=1, `inst_addr`=0x1C000000, `mem_addr_ok`=1 at cycle 0, `mem_data_ok`=1 with `mem_rdata`=0x02800C0C at cycle 2 → `inst_addr_ok`=1 at cycle 0; `inst_data_ok`=1 with `inst_rdata`=0x02800C0C at cycle 2; `data_data_ok` stays 0.
- Priority and lock: `inst_req` and `data_req` both 1, `mem_addr_ok`=0 for 3 cycles then 1 → data granted; `mem_addr`=`data_addr` is stable all 4 cycles; the inst request is accepted on the following cycle.
- Outstanding limit and order: accept data store then inst fetch with `mem_data_ok` held low → `mem_req`=0 afterward with `out_cnt`=2. Two responses on consecutive cycles → `data_data_ok` then `inst_data_ok`.
- Starvation guard: `inst_req` held 1 and `data_req` held 1, `mem_addr_ok`=1 every cycle → exactly 4 data accepts, then 1 inst accept, then data resumes.
- Unexpected response: reset, then `mem_data_ok`=1 with nothing outstanding → `err_unexp`=1 and stays 1; both `*_data_ok` stay 0.
- Reset mid-operation: 2 outstanding, assert `resetn`=0 → `mem_req`=0 immediately; after release, `out_cnt`=0 and a fresh fetch completes normally.
